// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and FSM state encodings.
package axi_lite_pkg;

  localparam int unsigned RESP_WIDTH_DEF = 3;

  localparam logic [RESP_WIDTH_DEF-1:0] RESP_OKAY   = 3'b000;
  localparam logic [RESP_WIDTH_DEF-1:0] RESP_SLVERR = 3'b010;

  // Write channel FSM: tracks which half of the AW/W pair has been taken.
  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } wr_state_e;

  // Read channel FSM.
  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_lite_mem_array.sv
// Word flop array with one byte-enabled write port and one registered read port.
module axi_lite_mem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        widx_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    re_i,
  input  logic [IDX_W-1:0]        ridx_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage: async clear, byte-lane write on enabled strobes only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) begin
          mem_q[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Read register: samples the pre-write contents on a same-edge collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[ridx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI-Lite single-beat word memory endpoint with OKAY/SLVERR responses.
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = RESP_WIDTH_DEF,
  parameter int unsigned MEM_DEPTH  = 16
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned WORD_W = ADDR_WIDTH - 2;
  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [RESP_WIDTH-1:0] OKAY_R   = RESP_WIDTH'(RESP_OKAY);
  localparam logic [RESP_WIDTH-1:0] SLVERR_R = RESP_WIDTH'(RESP_SLVERR);

  wr_state_e w_state_q, w_state_d;
  rd_state_e r_state_q, r_state_d;

  logic [WORD_W-1:0]     awword_q, awword_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [RESP_WIDTH-1:0] bresp_q, bresp_d;
  logic [RESP_WIDTH-1:0] rresp_q, rresp_d;

  logic                  aw_hs_c, w_hs_c, ar_hs_c;
  logic                  commit_c, wr_ok_c, rd_ok_c;
  logic [WORD_W-1:0]     cmt_word_c, rd_word_c;
  logic [DATA_WIDTH-1:0] cmt_data_c;
  logic [STRB_W-1:0]     cmt_strb_c;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // Readies decode from state and are held low while reset is asserted.
  assign s_axi_awready = s_axi_aresetn &
                         ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_DATA));
  assign s_axi_wready  = s_axi_aresetn &
                         ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_ADDR));
  assign s_axi_arready = s_axi_aresetn & (r_state_q == R_IDLE);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_rvalid  = (r_state_q == R_DATA);

  assign aw_hs_c = s_axi_awvalid & s_axi_awready;
  assign w_hs_c  = s_axi_wvalid  & s_axi_wready;
  assign ar_hs_c = s_axi_arvalid & s_axi_arready;

  // The pair completes with whichever half arrives now plus any held half.
  assign cmt_word_c = aw_hs_c ? s_axi_awaddr[ADDR_WIDTH-1:2] : awword_q;
  assign cmt_data_c = w_hs_c  ? s_axi_wdata : wdata_q;
  assign cmt_strb_c = w_hs_c  ? s_axi_wstrb[STRB_W-1:0] : wstrb_q;
  assign rd_word_c  = s_axi_araddr[ADDR_WIDTH-1:2];

  assign wr_ok_c = 32'(cmt_word_c) < MEM_DEPTH;
  assign rd_ok_c = 32'(rd_word_c)  < MEM_DEPTH;

  // Write FSM next state and commit strobe.
  always_comb begin
    w_state_d = w_state_q;
    commit_c  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) begin
          w_state_d = W_RESP;
          commit_c  = 1'b1;
        end else if (aw_hs_c) begin
          w_state_d = W_HAVE_ADDR;
        end else if (w_hs_c) begin
          w_state_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs_c) begin
          w_state_d = W_RESP;
          commit_c  = 1'b1;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs_c) begin
          w_state_d = W_RESP;
          commit_c  = 1'b1;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE: if (ar_hs_c)      r_state_d = R_DATA;
      R_DATA: if (s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Held halves of a split write, and responses that stay put until accepted.
  always_comb begin
    awword_d = aw_hs_c ? s_axi_awaddr[ADDR_WIDTH-1:2] : awword_q;
    wdata_d  = w_hs_c ? s_axi_wdata : wdata_q;
    wstrb_d  = w_hs_c ? s_axi_wstrb[STRB_W-1:0] : wstrb_q;
    bresp_d  = bresp_q;
    rresp_d  = rresp_q;
    if (commit_c) begin
      bresp_d = wr_ok_c ? OKAY_R : SLVERR_R;
    end
    if (ar_hs_c) begin
      rresp_d = rd_ok_c ? OKAY_R : SLVERR_R;
    end
  end

  // State and datapath registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awword_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= '0;
      rresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awword_q  <= awword_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
    end
  end

  axi_lite_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i   (s_axi_aclk),
    .rst_ni  (s_axi_aresetn),
    .we_i    (commit_c & wr_ok_c),
    .widx_i  (cmt_word_c[IDX_W-1:0]),
    .wdata_i (cmt_data_c),
    .wstrb_i (cmt_strb_c),
    .re_i    (ar_hs_c),
    .ridx_i  (rd_word_c[IDX_W-1:0]),
    .rdata_o (arr_rdata)
  );

  // Out-of-range reads return zero regardless of the aliased array word.
  assign s_axi_rdata = (rresp_q == SLVERR_R) ? '0 : arr_rdata;
  assign s_axi_bresp = bresp_q;
  assign s_axi_rresp = rresp_q;

  // Byte offset bits and the spare strobe bit carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi_wstrb[STRB_W], s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed testbench for axi_lite_mem_slave: vector table plus corner sequences.
module tb_axi_lite_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [4:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [2:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [2:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] OK  = 3'b000;
  localparam logic [2:0] ERR = 3'b010;

  always #5 clk = ~clk;

  axi_lite_mem_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .RESP_WIDTH (3),
    .MEM_DEPTH  (16)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [4:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [2:0]  resp;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic add_wr(input string n, input logic [7:0] a, input logic [31:0] d,
                        input logic [4:0] s, input int awd, input int wd, input logic [2:0] r);
    vec_t v;
    v.wr = 1'b1; v.addr = a; v.data = d; v.strb = s;
    v.aw_dly = awd; v.w_dly = wd; v.resp = r; v.rdata = '0; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic add_rd(input string n, input logic [7:0] a, input logic [2:0] r,
                        input logic [31:0] d);
    vec_t v;
    v.wr = 1'b0; v.addr = a; v.data = '0; v.strb = '0;
    v.aw_dly = 0; v.w_dly = 0; v.resp = r; v.rdata = d; v.name = n;
    vecs.push_back(v);
  endtask

  // Full write transaction; AW and W each start after their own cycle delay.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                           input int aw_dly, input int w_dly, output logic [2:0] resp);
    int n;
    fork
      begin
        repeat (aw_dly + 1) @(negedge clk);
        awaddr = a; awvalid = 1'b1;
        for (int k = 0; k < 50 && !awready; k++) @(negedge clk);
        @(negedge clk);
        awvalid = 1'b0;
      end
      begin
        repeat (w_dly + 1) @(negedge clk);
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int k = 0; k < 50 && !wready; k++) @(negedge clk);
        @(negedge clk);
        wvalid = 1'b0;
      end
    join
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) begin
      timeout_fail("bvalid_wait");
      resp = 3'b111;
    end else begin
      resp = bresp;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [2:0] resp, output logic [31:0] d);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    for (int k = 0; k < 50 && !arready; k++) @(negedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) begin
      timeout_fail("rvalid_wait");
      resp = 3'b111;
      d = 32'hFFFF_FFFF;
    end else begin
      resp = rresp;
      d = rdata;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rs;
    logic [31:0] rd;

    // Reset phase.
    repeat (2) @(negedge clk);
    check("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
    check("rst_readies", {29'd0, awready, wready, arready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_readies", {29'd0, awready, wready, arready}, 32'd7);
    check("post_rst_outs", {26'd0, bresp, rresp}, 32'd0);
    check("post_rst_rdata", rdata, 32'd0);

    // Directed vector table.
    add_rd("rd00_reset",    8'h00, OK,  32'h0000_0000);
    add_wr("wr08_same",     8'h08, 32'h0000_0038, 5'h0F, 0, 0, OK);
    add_rd("rd08",          8'h08, OK,  32'h0000_0038);
    add_wr("wr0C_aw_first", 8'h0C, 32'hAABB_CCDD, 5'h05, 0, 3, OK);
    add_rd("rd0C",          8'h0C, OK,  32'h00BB_00DD);
    add_wr("wr10_w_first",  8'h10, 32'hAABB_CCDD, 5'h05, 3, 0, OK);
    add_rd("rd10",          8'h10, OK,  32'h00BB_00DD);
    add_wr("wr40_oor",      8'h40, 32'hFFFF_FFFF, 5'h0F, 0, 0, ERR);
    add_rd("rd40_oor",      8'h40, ERR, 32'h0000_0000);
    add_rd("rd00_no_alias", 8'h00, OK,  32'h0000_0000);
    add_rd("rdFC_oor",      8'hFC, ERR, 32'h0000_0000);
    add_wr("wr14_nostrb",   8'h14, 32'h1234_5678, 5'h00, 0, 0, OK);
    add_rd("rd14",          8'h14, OK,  32'h0000_0000);
    add_wr("wr3D_top",      8'h3D, 32'hCAFE_F00D, 5'h1F, 0, 0, OK);
    add_rd("rd3C_top",      8'h3C, OK,  32'hCAFE_F00D);
    add_wr("wr0E_merge",    8'h0E, 32'h1122_3344, 5'h0A, 1, 0, OK);
    add_rd("rd0C_merge",    8'h0F, OK,  32'h11BB_33DD);
    add_rd("rd08_intact",   8'h08, OK,  32'h0000_0038);

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, rs);
        check({vecs[i].name, "_bresp"}, {29'd0, rs}, {29'd0, vecs[i].resp});
      end else begin
        axi_read(vecs[i].addr, rs, rd);
        check({vecs[i].name, "_rresp"}, {29'd0, rs}, {29'd0, vecs[i].resp});
        check({vecs[i].name, "_rdata"}, rd, vecs[i].rdata);
      end
    end

    // Back-pressure on both response channels at once.
    @(negedge clk);
    awaddr = 8'h18; wdata = 32'h5A5A_5A5A; wstrb = 5'h0F; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h08; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_valids", {30'd0, bvalid, rvalid}, 32'd3);
      check("bp_resps", {26'd0, bresp, rresp}, 32'd0);
      check("bp_rdata", rdata, 32'h0000_0038);
      @(negedge clk);
    end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    check("bp_release", {30'd0, bvalid, rvalid}, 32'd0);
    axi_read(8'h18, rs, rd);
    check("bp_rd18", rd, 32'h5A5A_5A5A);

    // Same-edge write commit and read of one word.
    axi_write(8'h04, 32'h0000_0077, 5'h0F, 0, 0, rs);
    check("coll_pre_bresp", {29'd0, rs}, {29'd0, OK});
    @(negedge clk);
    awaddr = 8'h04; wdata = 32'h0000_0011; wstrb = 5'h0F; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h04; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("coll_valids", {30'd0, bvalid, rvalid}, 32'd3);
    check("coll_old_rdata", rdata, 32'h0000_0077);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    axi_read(8'h04, rs, rd);
    check("coll_new_rdata", rd, 32'h0000_0011);

    // Reset asserted while a write response is pending.
    @(negedge clk);
    awaddr = 8'h20; wdata = 32'hDEAD_BEEF; wstrb = 5'h0F; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("wresp_pending", {31'd0, bvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_bvalid_drop", {31'd0, bvalid}, 32'd0);
    check("async_awready_low", {31'd0, awready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_awready", {31'd0, awready}, 32'd1);
    axi_read(8'h20, rs, rd);
    check("rel_rd20", rd, 32'h0000_0000);
    axi_read(8'h08, rs, rd);
    check("rel_rd08_cleared", rd, 32'h0000_0000);
    check("rel_rd08_rresp", {29'd0, rs}, {29'd0, OK});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
